sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

Byte-level SD-card responder for SPI mode: the card side of the link the SD SPI host drives. It sits behind an SPI slave shift register that strobes `DataClock` once per completed byte. It decodes CMD0, CMD55, ACMD41 and CMD17 and returns R1 responses. For CMD17 it streams a 512-byte block from a synchronous byte memory, so the host read path can be simulated and looped back on-board without a physical card.

## Interface
- `NCR`, default 1: 0xFF filler bytes between the command CRC byte and R1; legal range 1..8.
- `NAC`, default 2: 0xFF filler bytes between the CMD17 R1 and the 0xFE token; legal range 1..255.
- `INIT_POLLS`, default 2: number of ACMD41 responses of 0x01 before the first 0x00.
- `MEM_AW`, default 32: width of the memory byte address.
- `DataClock`  in  1: byte strobe from the SPI slave shifter.
- `Reset`  in  1: reset, synchronous, active-high.
- `SPI_CS`  in  1: chip select, active-low, sampled on `DataClock`.
- `RxByte`  in  8: byte just received from the host, valid at each `DataClock` rising edge.
- `TxByte`  out  8: registered byte the shifter sends during the next byte period.
- `MemAddr`  out  MEM_AW: byte address to the block store.
- `MemRead`  out  1: read enable. `MemData` is valid on the edge after `MemAddr`/`MemRead`.
- `MemData`  in  8: memory read data, one-`DataClock` latency.
- `CardIdle`  out  1: card idle flag, R1 bit 0.
- `Reading`  out  1: high from token emission through the second CRC byte.

## Operation
- FSM states: HUNT, ARGS, CRC, NCR_WAIT, RESP, NAC_WAIT, TOKEN, DATA, CRC1, CRC2. One transition evaluation per `DataClock` edge.
- **HUNT.** `RxByte[7:6]==2'b01` latches `Cmd=RxByte[5:0]` and goes to ARGS. Any other byte stays in HUNT. `TxByte=0xFF`.
- **ARGS.** Shifts 4 bytes MSB-first into the 32-bit `Arg`, then goes to CRC.
- **CRC.** Latches the CRC byte and computes R1, then goes to NCR_WAIT.
- R1 rules, where `i` = `CardIdle` at decode:
  - CMD0 with CRC 0x95: set idle, clear app, R1=0x01.
  - CMD0 with any other CRC: R1=0x09, no state change.
  - CMD55: set app, R1={7'b0,i}.
  - CMD41 with app set: poll count < INIT_POLLS → count+1, R1=0x01. Otherwise clear idle, R1=0x00. App is cleared in both cases.
  - CMD41 without app set: R1=0x05 if idle, else 0x04.
  - CMD17 while idle: R1=0x05, no data.
  - CMD17 while not idle: R1=0x00 and a data phase follows.
  - Any other Cmd: R1={5'b0,1'b1,1'b0,i}, and app is cleared.
  - CRC is checked only for CMD0.
- **NCR_WAIT.** Emits NCR bytes of 0xFF, then RESP.
- **RESP.** Emits R1. Next state is NAC_WAIT if a data phase follows, else HUNT.
- **NAC_WAIT.** Emits NAC bytes of 0xFF.
  - `MemAddr=Arg[MEM_AW-1:0]` and `MemRead=1` are asserted on the last NAC_WAIT edge.
- **TOKEN.** Emits 0xFE. `MemAddr` increments and `MemRead` stays 1.
- **DATA.** Emits `MemData` for 512 bytes, index 0..511.
  - `MemAddr` increments each edge; `MemRead` stays 1 while index < 511.
  - Address arithmetic is modulo 2^MEM_AW.
  - Index counter is 10 bits; exit on index==511 to CRC1.
- **CRC1, CRC2.** Emit 0xFF, 0xFF, then HUNT. `Reading` drops on the edge leaving CRC2.
- Poll count is 3 bits and saturates. It is cleared on reset and on CMD0.
- `RxByte` is ignored in NCR_WAIT through CRC2. No CMD12 support: a command byte arriving mid-block is discarded.

## Timing
- All outputs are registered on `DataClock`.
- Reset values: `TxByte`=0xFF, `MemAddr`=0, `MemRead`=0, `CardIdle`=1, `Reading`=0. Also cleared on reset: state=HUNT, app=0, poll count=0.
- `Reset` has priority over `SPI_CS` and over the FSM. Asserting reset mid-block aborts immediately.
- `SPI_CS`=1 at an edge forces: state=HUNT, `TxByte`=0xFF, `MemRead`=0, `Reading`=0.
  - `CardIdle`, app and poll count are retained.
  - The byte on that edge is not decoded.
- Command latency: the CRC byte is received at edge n. `TxByte` is 0xFF for edges n..n+NCR-1 and R1 at edge n+NCR, so R1 appears NCR byte periods later.
- CMD17 latency: the 0xFE token follows R1 after NAC filler bytes. Data byte k is emitted at token edge + 1 + k.
- Back-to-back commands: a command start byte on the edge after RESP/CRC2 returns to HUNT is decoded.

## Test plan
- **Reset and CMD0.**
  - Stimulus: reset, then with CS low send 40 00 00 00 00 95.
  - Required: TxByte is FF for 1 byte, then 01. `CardIdle`=1.
  - Then send 40 00 00 00 00 00 → R1 09.
- **Init sequence, INIT_POLLS=2.** Send CMD55 + ACMD41 (69 40 00 00 00 FF) three times.
  - Required ACMD41 R1 sequence: 01, 01, 00. `CardIdle` goes 1→0 on the third R1 edge.
  - Every CMD55 response equals the current idle bit.
- **CMD17 while idle.** Send 51 00 00 02 00 01 → R1 05. No FE token, `MemRead` stays 0.
- **CMD17 after init.**
  - Memory model returns addr[7:0]. Send 51 00 00 02 00 01.
  - Required: FF, 00, FF, FF, FE, then 00..FF twice (512 bytes), FF, FF.
  - `MemAddr` starts at 0x0000_0200. `Reading` is high for 515 edges.
- **CS deassert mid-block.** Raise CS at data byte 100.
  - Required: the next edge gives `TxByte`=FF, `Reading`=0, `MemRead`=0, `CardIdle` still 0.
  - A following CMD17 works normally.
- **Filler and illegal commands.**
  - Random non-01xxxxxx bytes in HUNT → no response.
  - CMD9 (49 ...) after init → R1 04.
  - Reset asserted mid-NAC_WAIT → all outputs take reset values on the next edge.

Source files
------------

// File: rtl/sd_spi_responder_if.sv
// Byte-level link between the SD SPI responder and its host-side shifter and block store.
// Latency: none, plain wires; every timing relationship is set by the responder.
// Backpressure: none; the link is paced by the shifter's byte strobe.
interface sd_spi_responder_if #(
    parameter int MEM_AW = 32
) ();
    logic              SPI_CS;
    logic [7:0]        RxByte;
    logic [7:0]        TxByte;
    logic [MEM_AW-1:0] MemAddr;
    logic              MemRead;
    logic [7:0]        MemData;
    logic              CardIdle;
    logic              Reading;

    // Host side: the SPI shifter plus the block store it loops back from.
    modport master (
        output SPI_CS, RxByte, MemData,
        input  TxByte, MemAddr, MemRead, CardIdle, Reading
    );

    // Card side: the responder itself.
    modport slave (
        input  SPI_CS, RxByte, MemData,
        output TxByte, MemAddr, MemRead, CardIdle, Reading
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: decodes CMD0/CMD55/ACMD41/CMD17, returns R1 and streams 512-byte blocks.
// Latency: R1 lands NCR byte periods after the CRC byte; the 0xFE token follows R1 after NAC filler bytes.
// Backpressure: none; one transition per byte strobe, chip select high forces the link back to hunting.
module sd_spi_responder #(
    parameter int NCR        = 1,
    parameter int NAC        = 2,
    parameter int INIT_POLLS = 2,
    parameter int MEM_AW     = 32   // at most 32: the address is taken from the command argument
) (
    input  logic              DataClock,
    input  logic              Reset,
    sd_spi_responder_if.slave bus
);

    typedef enum logic [3:0] {
        HUNT,
        ARGS,
        CRC,
        NCR_WAIT,
        RESP,
        NAC_WAIT,
        TOKEN,
        DATA,
        CRC1,
        CRC2
    } state_t;

    localparam logic [7:0]        NCR_LAST     = 8'(NCR - 1);
    localparam logic [7:0]        NAC_LAST     = 8'(NAC - 1);
    localparam logic [31:0]       INIT_POLLS_U = INIT_POLLS;
    localparam logic [9:0]        LAST_IDX     = 10'd511;
    localparam logic [MEM_AW-1:0] ADDR_ONE     = {{(MEM_AW-1){1'b0}}, 1'b1};

    // FSM and command capture
    state_t            state_q, state_d;
    logic [5:0]        cmd_q, cmd_d;
    logic [31:0]       arg_q, arg_d;
    logic [7:0]        cnt_q, cnt_d;       // argument byte index, then filler countdown
    logic [9:0]        idx_q, idx_d;       // data byte index within the block

    // Decoded command outcome, held until R1 goes out so a command takes effect with its response
    logic [7:0]        r1_q, r1_d;
    logic              data_q, data_d;
    logic              idle_nxt_q, idle_nxt_d;
    logic              app_nxt_q, app_nxt_d;
    logic [2:0]        poll_nxt_q, poll_nxt_d;

    // Card state that survives chip select
    logic              app_q, app_d;
    logic [2:0]        poll_q, poll_d;

    // Registered outputs
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              card_idle_q, card_idle_d;
    logic              reading_q, reading_d;

    // Decode results for the command in cmd_q, using the byte on the bus as its CRC
    logic [7:0]        dec_r1;
    logic              dec_data;
    logic              dec_idle;
    logic              dec_app;
    logic [2:0]        dec_poll;
    logic [2:0]        poll_inc;

    // Saturating ACMD41 poll counter increment
    always_comb begin
        poll_inc = (poll_q == 3'd7) ? 3'd7 : (poll_q + 3'd1);
    end

    // R1 and the card-state update each supported command would cause
    always_comb begin
        dec_r1   = {5'b0, 1'b1, 1'b0, card_idle_q};   // illegal command
        dec_data = 1'b0;
        dec_idle = card_idle_q;
        dec_app  = 1'b0;
        dec_poll = poll_q;
        case (cmd_q)
            6'd0: begin
                if (bus.RxByte == 8'h95) begin
                    dec_r1   = 8'h01;
                    dec_idle = 1'b1;
                    dec_poll = 3'd0;
                end else begin
                    dec_r1  = 8'h09;                   // CRC error, nothing changes
                    dec_app = app_q;
                end
            end
            6'd55: begin
                dec_r1  = {7'b0, card_idle_q};
                dec_app = 1'b1;
            end
            6'd41: begin
                if (app_q) begin
                    if ({29'd0, poll_q} < INIT_POLLS_U) begin
                        dec_r1   = 8'h01;
                        dec_poll = poll_inc;
                    end else begin
                        dec_r1   = 8'h00;
                        dec_idle = 1'b0;
                    end
                end else begin
                    dec_r1 = card_idle_q ? 8'h05 : 8'h04;
                end
            end
            6'd17: begin
                dec_app = app_q;
                if (card_idle_q) begin
                    dec_r1 = 8'h05;
                end else begin
                    dec_r1   = 8'h00;
                    dec_data = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state and output logic, with chip select overriding the FSM
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        r1_d        = r1_q;
        data_d      = data_q;
        idle_nxt_d  = idle_nxt_q;
        app_nxt_d   = app_nxt_q;
        poll_nxt_d  = poll_nxt_q;
        app_d       = app_q;
        poll_d      = poll_q;
        tx_byte_d   = 8'hFF;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = 1'b0;
        card_idle_d = card_idle_q;
        reading_d   = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.RxByte[7:6] == 2'b01) begin
                    cmd_d   = bus.RxByte[5:0];
                    cnt_d   = 8'd0;
                    state_d = ARGS;
                end
            end
            ARGS: begin
                arg_d = {arg_q[23:0], bus.RxByte};
                if (cnt_q == 8'd3) begin
                    state_d = CRC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CRC: begin
                r1_d       = dec_r1;
                data_d     = dec_data;
                idle_nxt_d = dec_idle;
                app_nxt_d  = dec_app;
                poll_nxt_d = dec_poll;
                cnt_d      = NCR_LAST;
                state_d    = NCR_WAIT;
            end
            NCR_WAIT: begin
                if (cnt_q == 8'd0) begin
                    tx_byte_d   = r1_q;
                    card_idle_d = idle_nxt_q;
                    app_d       = app_nxt_q;
                    poll_d      = poll_nxt_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (data_q) begin
                    cnt_d   = NAC_LAST;
                    state_d = NAC_WAIT;
                end else begin
                    state_d = HUNT;
                end
            end
            NAC_WAIT: begin
                if (cnt_q == 8'd0) begin
                    tx_byte_d  = 8'hFE;
                    mem_addr_d = arg_q[MEM_AW-1:0];
                    mem_read_d = 1'b1;
                    reading_d  = 1'b1;
                    state_d    = TOKEN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            TOKEN: begin
                tx_byte_d  = bus.MemData;
                mem_addr_d = mem_addr_q + ADDR_ONE;
                mem_read_d = 1'b1;
                reading_d  = 1'b1;
                idx_d      = 10'd0;
                state_d    = DATA;
            end
            DATA: begin
                reading_d  = 1'b1;
                mem_addr_d = mem_addr_q + ADDR_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = CRC1;
                end else begin
                    tx_byte_d  = bus.MemData;
                    idx_d      = idx_q + 10'd1;
                    mem_read_d = (idx_q != (LAST_IDX - 10'd1));
                end
            end
            CRC1: begin
                reading_d = 1'b1;
                state_d   = CRC2;
            end
            CRC2: begin
                state_d = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (bus.SPI_CS) begin
            state_d     = HUNT;
            tx_byte_d   = 8'hFF;
            mem_addr_d  = mem_addr_q;
            mem_read_d  = 1'b0;
            reading_d   = 1'b0;
            card_idle_d = card_idle_q;
            app_d       = app_q;
            poll_d      = poll_q;
        end
    end

    // State and output registers, synchronous reset taking priority over everything
    always_ff @(posedge DataClock) begin
        if (Reset) begin
            state_q     <= HUNT;
            cmd_q       <= 6'd0;
            arg_q       <= 32'd0;
            cnt_q       <= 8'd0;
            idx_q       <= 10'd0;
            r1_q        <= 8'hFF;
            data_q      <= 1'b0;
            idle_nxt_q  <= 1'b1;
            app_nxt_q   <= 1'b0;
            poll_nxt_q  <= 3'd0;
            app_q       <= 1'b0;
            poll_q      <= 3'd0;
            tx_byte_q   <= 8'hFF;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            card_idle_q <= 1'b1;
            reading_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            r1_q        <= r1_d;
            data_q      <= data_d;
            idle_nxt_q  <= idle_nxt_d;
            app_nxt_q   <= app_nxt_d;
            poll_nxt_q  <= poll_nxt_d;
            app_q       <= app_d;
            poll_q      <= poll_d;
            tx_byte_q   <= tx_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            card_idle_q <= card_idle_d;
            reading_q   <= reading_d;
        end
    end

    assign bus.TxByte   = tx_byte_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.CardIdle = card_idle_q;
    assign bus.Reading  = reading_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for the SD SPI responder: command table, directed abort sequences, then random traffic.
// Latency: expected byte streams are laid out edge by edge from the CRC byte onwards.
// Backpressure: none; the bench supplies one byte per strobe.
module tb_sd_spi_responder;
    localparam int NCR        = 1;
    localparam int NAC        = 2;
    localparam int INIT_POLLS = 2;
    localparam int MEM_AW     = 32;
    localparam int BLK        = 512;

    typedef struct packed {
        logic [7:0]  tx;
        logic        rd;
        logic        mr;
        logic        idle;
        logic        chk;
        logic [31:0] addr;
    } exp_t;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [7:0]  crc;
        logic [7:0]  r1;
        logic        data;
        logic        idle_after;
    } vec_t;

    logic DataClock = 1'b0;
    logic Reset     = 1'b1;
    int   n_vec     = 0;
    int   n_bad     = 0;

    // Reference card state
    logic m_idle;
    logic m_app;
    int   m_polls;

    sd_spi_responder_if #(.MEM_AW(MEM_AW)) bus ();

    sd_spi_responder #(
        .NCR(NCR), .NAC(NAC), .INIT_POLLS(INIT_POLLS), .MEM_AW(MEM_AW)
    ) dut (
        .DataClock(DataClock),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 DataClock = ~DataClock;

    // Block store: registered address from the responder, byte back by the next strobe
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[23:16];
    endfunction
    assign bus.MemData = mem_byte(bus.MemAddr);

    function automatic exp_t mk(input logic [7:0] tx, input logic rd, input logic mr,
                                input logic idle, input logic chk, input logic [31:0] addr);
        exp_t e;
        e.tx = tx; e.rd = rd; e.mr = mr; e.idle = idle; e.chk = chk; e.addr = addr;
        return e;
    endfunction

    task automatic tick(input logic cs, input logic [7:0] rx);
        bus.SPI_CS = cs;
        bus.RxByte = rx;
        @(posedge DataClock);
        #1;
    endtask

    task automatic check_out(input exp_t e, input string tag, input int idx);
        logic [10:0] got, want;
        got  = {bus.TxByte, bus.Reading, bus.MemRead, bus.CardIdle};
        want = {e.tx, e.rd, e.mr, e.idle};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: tx/rd/mr/idle got %02h/%b/%b/%b want %02h/%b/%b/%b",
                     tag, idx, got[10:3], got[2], got[1], got[0],
                     want[10:3], want[2], want[1], want[0]);
        end
        if (e.chk) begin
            n_vec++;
            if (bus.MemAddr !== e.addr) begin
                n_bad++;
                $display("FAIL %s_addr[%0d]: MemAddr got %08h want %08h", tag, idx, bus.MemAddr, e.addr);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        logic [43:0] got;
        got = {bus.TxByte, bus.MemAddr, bus.MemRead, bus.CardIdle, bus.Reading, 1'b0};
        n_vec++;
        if (got !== {8'hFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: tx/addr/mr/idle/rd got %02h/%08h/%b/%b/%b want ff/00000000/0/1/0",
                     tag, bus.TxByte, bus.MemAddr, bus.MemRead, bus.CardIdle, bus.Reading);
        end
    endtask

    // Card behaviour from the command rules, applied at decode
    task automatic model_cmd(input logic [5:0] cmd, input logic [7:0] crc,
                             output logic [7:0] r1, output logic data);
        data = 1'b0;
        if (cmd == 6'd0) begin
            if (crc == 8'h95) begin
                m_idle = 1'b1; m_app = 1'b0; m_polls = 0; r1 = 8'h01;
            end else begin
                r1 = 8'h09;
            end
        end else if (cmd == 6'd55) begin
            r1 = {7'b0, m_idle};
            m_app = 1'b1;
        end else if (cmd == 6'd41) begin
            if (m_app) begin
                if (m_polls < INIT_POLLS) begin
                    m_polls = (m_polls < 7) ? m_polls + 1 : 7;
                    r1 = 8'h01;
                end else begin
                    m_idle = 1'b0;
                    r1 = 8'h00;
                end
                m_app = 1'b0;
            end else begin
                r1 = m_idle ? 8'h05 : 8'h04;
            end
        end else if (cmd == 6'd17) begin
            if (m_idle) r1 = 8'h05;
            else begin r1 = 8'h00; data = 1'b1; end
        end else begin
            r1 = {5'b0, 1'b1, 1'b0, m_idle};
            m_app = 1'b0;
        end
    endtask

    // Sends one six-byte command and checks every edge up to the return to HUNT.
    // abort_at >= 0 replaces that edge of the response stream with CS high or Reset.
    task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] crc,
                            input logic [7:0] r1, input logic data, input logic idle_b,
                            input logic idle_a, input int abort_at, input logic abort_rst,
                            input string tag);
        logic [7:0] b [6];
        exp_t       q [$];
        logic [31:0] a;
        bit         stop;
        b[0] = {2'b01, cmd};
        b[1] = arg[31:24]; b[2] = arg[23:16]; b[3] = arg[15:8]; b[4] = arg[7:0];
        b[5] = crc;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, b[i]);
            check_out(mk(8'hFF, 1'b0, 1'b0, idle_b, 1'b0, 32'h0), {tag, "_cmd"}, i);
        end
        for (int i = 0; i < NCR; i++) q.push_back(mk(8'hFF, 1'b0, 1'b0, idle_b, 1'b0, 32'h0));
        q.push_back(mk(r1, 1'b0, 1'b0, idle_a, 1'b0, 32'h0));
        if (data) begin
            for (int i = 0; i < NAC; i++) q.push_back(mk(8'hFF, 1'b0, 1'b0, idle_a, 1'b0, 32'h0));
            q.push_back(mk(8'hFE, 1'b1, 1'b1, idle_a, 1'b1, arg));
            for (int k = 0; k < BLK; k++) begin
                a = arg + 32'(k);
                q.push_back(mk(mem_byte(a), 1'b1, k < BLK - 1, idle_a, 1'b1, a + 32'd1));
            end
            q.push_back(mk(8'hFF, 1'b1, 1'b0, idle_a, 1'b0, 32'h0));
            q.push_back(mk(8'hFF, 1'b1, 1'b0, idle_a, 1'b0, 32'h0));
        end
        q.push_back(mk(8'hFF, 1'b0, 1'b0, idle_a, 1'b0, 32'h0));
        stop = 1'b0;
        for (int i = 0; i < q.size() && !stop; i++) begin
            if (i == abort_at) begin
                stop = 1'b1;
                if (abort_rst) begin
                    Reset = 1'b1;
                    tick(1'b0, 8'h51);
                    Reset = 1'b0;
                    check_reset({tag, "_reset"});
                end else begin
                    tick(1'b1, 8'h51);
                    check_out(mk(8'hFF, 1'b0, 1'b0, q[i-1].idle, 1'b0, 32'h0), {tag, "_csabort"}, i);
                end
            end else begin
                tick(1'b0, (i == 0) ? crc : 8'($urandom));
                check_out(q[i], tag, i);
            end
        end
    endtask

    vec_t        tbl [14];
    logic        cur_idle;
    logic        cs, idle_b, data;
    logic [7:0]  fb, r1, crc;
    logic [5:0]  cmd;
    logic [31:0] arg;
    int          nj, sel;

    initial begin
        bus.SPI_CS = 1'b1;
        bus.RxByte = 8'hFF;

        // cmd, arg, crc, R1, data phase, CardIdle after R1
        tbl[0]  = '{6'd0,  32'h0000_0000, 8'h95, 8'h01, 1'b0, 1'b1};
        tbl[1]  = '{6'd0,  32'h0000_0000, 8'h00, 8'h09, 1'b0, 1'b1};
        tbl[2]  = '{6'd17, 32'h0000_0200, 8'h01, 8'h05, 1'b0, 1'b1};
        tbl[3]  = '{6'd55, 32'h0000_0000, 8'hFF, 8'h01, 1'b0, 1'b1};
        tbl[4]  = '{6'd41, 32'h4000_0000, 8'hFF, 8'h01, 1'b0, 1'b1};
        tbl[5]  = '{6'd55, 32'h0000_0000, 8'hFF, 8'h01, 1'b0, 1'b1};
        tbl[6]  = '{6'd41, 32'h4000_0000, 8'hFF, 8'h01, 1'b0, 1'b1};
        tbl[7]  = '{6'd55, 32'h0000_0000, 8'hFF, 8'h01, 1'b0, 1'b1};
        tbl[8]  = '{6'd41, 32'h4000_0000, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{6'd55, 32'h0000_0000, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{6'd9,  32'h0000_0000, 8'hFF, 8'h04, 1'b0, 1'b0};
        tbl[11] = '{6'd41, 32'h4000_0000, 8'hFF, 8'h04, 1'b0, 1'b0};
        tbl[12] = '{6'd17, 32'h0000_0200, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[13] = '{6'd0,  32'h0000_0000, 8'h94, 8'h09, 1'b0, 1'b0};

        Reset = 1'b1;
        tick(1'b1, 8'hFF);
        tick(1'b0, 8'h40);
        check_reset("reset_state");
        Reset = 1'b0;

        cur_idle = 1'b1;
        for (int v = 0; v < 14; v++) begin
            send_cmd(tbl[v].cmd, tbl[v].arg, tbl[v].crc, tbl[v].r1, tbl[v].data,
                     cur_idle, tbl[v].idle_after, -1, 1'b0, $sformatf("tbl%0d", v));
            cur_idle = tbl[v].idle_after;
        end

        // Chip select raised right after data byte 100; the start byte on that edge is dropped
        send_cmd(6'd17, 32'h0000_1000, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0,
                 NCR + NAC + 103, 1'b0, "cs_mid_block");
        // Next block runs normally and its address wraps past the top of the space
        send_cmd(6'd17, 32'hFFFF_FF40, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, -1, 1'b0, "wrap_block");
        // Reset on the last filler edge before the token
        send_cmd(6'd17, 32'h0000_0400, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0,
                 NCR + NAC, 1'b1, "reset_mid_nac");

        m_idle = 1'b1; m_app = 1'b0; m_polls = 0;
        for (int it = 0; it < 40; it++) begin
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                cs = ($urandom_range(0, 3) == 0);
                fb = 8'($urandom);
                if (!cs && fb[7:6] == 2'b01) fb[7] = 1'b1;
                tick(cs, fb);
                check_out(mk(8'hFF, 1'b0, 1'b0, m_idle, 1'b0, 32'h0), "hunt_filler", j);
            end
            sel = $urandom_range(0, 9);
            arg = $urandom;
            crc = 8'($urandom);
            case (sel)
                0:       begin cmd = 6'd0; crc = 8'h95; end
                1:       cmd = 6'd0;
                2, 3:    cmd = 6'd55;
                4, 5:    cmd = 6'd41;
                6, 7:    begin
                    cmd = 6'd17;
                    if ($urandom_range(0, 2) == 0) arg = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                end
                8:       cmd = 6'd9;
                default: cmd = 6'($urandom);
            endcase
            idle_b = m_idle;
            model_cmd(cmd, crc, r1, data);
            send_cmd(cmd, arg, crc, r1, data, idle_b, m_idle, -1, 1'b0, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
